pwm_param_adjuster: RTL
=======================

// Module: pwm_param_adjuster
// PURPOSE
//  N-channel push-button parameter adjuster for PWM control.
//  - Each channel holds one W-bit setting (e.g. duty, period count) and has its own Inc/Dec buttons.
//  - Each button gets an internal debouncer and press-and-hold auto-repeat.
//  - Per-channel MIN/MAX/STEP/INIT; saturating or wrap-around mode.
//  - Sits between the board buttons and the PWM generator(s).
// PARAMETERS
//  N_CH         2           number of channels
//  W            24          setting width, bits
//  INIT_VEC     {24'd50,24'd250_000}   packed N_CH*W; reset value per channel (ch0 in LSBs)
//  MIN_VEC      {24'd0,24'd0}          packed N_CH*W; lower bound per channel
//  MAX_VEC      {24'd100,24'd500_000}  packed N_CH*W; upper bound per channel
//  STEP_VEC     {24'd10,24'd50_000}    packed N_CH*W; increment/decrement per channel
//  WRAP         0           0 = saturate at bounds, 1 = wrap MAX<->MIN
//  DB_CYCLES    1_000_000   debounce stable time, clocks (20 ms @ 50 MHz); >= 1
//  RPT_DELAY    25_000_000  hold time before auto-repeat starts, clocks; 0 = repeat disabled
//  RPT_RATE     5_000_000   auto-repeat interval, clocks; >= 1
// PORTS
//  CLK      in   1        system clock
//  Rstn     in   1        synchronous reset, active low
//  Inc      in   N_CH     raw increment buttons, active low (0 = pressed), asynchronous
//  Dec      in   N_CH     raw decrement buttons, active low, asynchronous
//  Value    out  N_CH*W   current settings, packed, ch0 in LSBs
//  Changed  out  N_CH     1-clock pulse when that channel's Value changed
//  AtMin    out  N_CH     Value == MIN for that channel
//  AtMax    out  N_CH     Value == MAX for that channel
// BEHAVIOUR
//  Reset (Rstn=0 at posedge CLK):
//  - Value = INIT, Changed = 0.
//  - All debounced states = released; all counters = 0.
//  - AtMin/AtMax are combinational from Value.
//  Input sync: 2-FF synchroniser per button.
//  Debounce:
//  - Per button, stable state S changes only after the synchronised input differs from S for DB_CYCLES consecutive clocks.
//  - Any agreeing sample clears the counter.
//  Events (per button):
//  - PRESS: S goes released -> pressed; one step event.
//  - Auto-repeat (RPT_DELAY != 0): while S stays pressed, an extra event fires RPT_DELAY clocks after PRESS, then every RPT_RATE clocks.
//  - Release stops repeat immediately and clears the hold counter.
//  Latency: Value updates one clock after the event, i.e. 2 + DB_CYCLES + 1 clocks after a clean raw press edge.
//  Arithmetic: computed in W+1 bits, so there is no silent overflow.
//  - Inc, saturate: Value+STEP > MAX -> MAX, else Value+STEP.
//  - Dec, saturate: Value < MIN+STEP -> MIN, else Value-STEP.
//  - Inc, wrap: Value == MAX -> MIN; Value+STEP > MAX -> MAX.
//  - Dec, wrap: Value == MIN -> MAX; Value-STEP < MIN -> MIN.
//  - Changed pulses only when the new Value != old Value. Saturated presses at a bound give no pulse.
//  Simultaneous events:
//  - Inc and Dec events on the same channel in the same clock cancel: no change, no pulse.
//  - Channels are fully independent; all may update in the same clock.
//  Reset mid-operation: all state restarts.
//  - A button held through reset release is seen as a new PRESS after DB_CYCLES (+2 sync).
//  Glitches shorter than DB_CYCLES clocks never produce events.
//  Out-of-range INIT or STEP=0 is illegal configuration; behaviour is not specified.
// TESTING  (N_CH=2, W=8, INIT={8'd5,8'd50}, MIN=0, MAX={8'd9,8'd100}, STEP={8'd2,8'd10}, DB=4, RPT_DELAY=20, RPT_RATE=5)
//  1. Reset, then hold Inc[0] low -> Value0 50->60 exactly 7 clks after edge; Changed[0] one pulse.
//  2. Glitch Inc[0] low for 3 clks -> no change. Low for 4 clks then high -> single step.
//  3. Press Inc[0] 6 times from 50 -> 60,70,80,90,100,100. 6th press: no Changed, AtMax[0]=1.
//  4. WRAP=1, ch1 at 9, press Inc[1] -> 0. Press Dec[1] -> 9. From 8, press Inc[1] -> 9.
//  5. Hold Dec[0] 40 clks past PRESS -> steps at PRESS, +20, +25, +30, +35, +40; 50 -> 0, saturates, AtMin[0]=1.
//  6. Inc[0] and Dec[0] events in the same clock -> Value0 unchanged. Assert Rstn=0 mid-hold -> Value0=50 on next clk.

Source files
------------

// File: rtl/pwm_param_adjuster.sv
// -----------------------------------------------------------------------------
// pwm_param_adjuster
//
// Push-button parameter adjuster for PWM control. There are N_CH channels.
// Each channel holds one W-bit setting, such as a duty or a period count.
// Each channel has its own Inc and Dec buttons. Each button goes through
// three steps:
//   - a 2-FF synchroniser,
//   - a debouncer,
//   - a press-and-hold auto-repeat generator.
// The resulting step events move the setting within a per-channel
// [MIN, MAX] range. Each channel has its own STEP. The setting either
// saturates at the bounds or wraps around (WRAP).
//
// Ports
//   CLK      in   1        system clock
//   Rstn     in   1        synchronous reset, active low
//   Inc      in   N_CH     raw increment buttons, active low, asynchronous
//   Dec      in   N_CH     raw decrement buttons, active low, asynchronous
//   Value    out  N_CH*W   current settings, packed, ch0 in LSBs
//   Changed  out  N_CH     1-clock pulse when that channel's Value changed
//   AtMin    out  N_CH     Value == MIN for that channel
//   AtMax    out  N_CH     Value == MAX for that channel
//
// Latency from a clean raw press edge to the Value update is
// 2 (sync) + DB_CYCLES (debounce) + 1 (update) clocks.
// -----------------------------------------------------------------------------
module pwm_param_adjuster #(
   parameter int                N_CH      = 2,
   parameter int                W         = 24,
   parameter logic [N_CH*W-1:0] INIT_VEC  = {24'd50, 24'd250_000},
   parameter logic [N_CH*W-1:0] MIN_VEC   = {24'd0, 24'd0},
   parameter logic [N_CH*W-1:0] MAX_VEC   = {24'd100, 24'd500_000},
   parameter logic [N_CH*W-1:0] STEP_VEC  = {24'd10, 24'd50_000},
   parameter int                WRAP      = 0,
   parameter int                DB_CYCLES = 1_000_000,
   parameter int                RPT_DELAY = 25_000_000,
   parameter int                RPT_RATE  = 5_000_000
) (
   input  logic              CLK,
   input  logic              Rstn,
   input  logic [N_CH-1:0]   Inc,
   input  logic [N_CH-1:0]   Dec,
   output logic [N_CH*W-1:0] Value,
   output logic [N_CH-1:0]   Changed,
   output logic [N_CH-1:0]   AtMin,
   output logic [N_CH-1:0]   AtMax
);

   // Buttons are handled uniformly: indices [N_CH-1:0] are Inc and
   // indices [2*N_CH-1:N_CH] are Dec.
   localparam int NB       = 2 * N_CH;

   // The debounce counter only ever holds 0 .. DB_CYCLES-1.
   localparam int DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   // The hold counter counts clocks since the last event, up to the larger
   // of the first-repeat delay and the repeat interval.
   localparam int HOLD_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
   localparam int HC_W     = $clog2(HOLD_MAX + 1);
   localparam logic [HC_W-1:0] HOLD_FIRST = HC_W'(RPT_DELAY);
   localparam logic [HC_W-1:0] HOLD_RATE  = HC_W'(RPT_RATE);

   // Increment with bound handling. The sum is formed in W+1 bits, so a
   // setting near the top of the W-bit range cannot overflow silently.
   function automatic logic [W-1:0] step_up(input logic [W-1:0] v,
                                            input logic [W-1:0] lo,
                                            input logic [W-1:0] hi,
                                            input logic [W-1:0] st);
      logic [W:0] sum;
      sum = {1'b0, v} + {1'b0, st};
      if ((WRAP != 0) && (v == hi))
         return lo;
      if (sum > {1'b0, hi})
         return hi;
      return sum[W-1:0];
   endfunction

   // Decrement with bound handling. The floor test compares v against
   // lo+st in W+1 bits rather than forming v-st, which could underflow.
   function automatic logic [W-1:0] step_down(input logic [W-1:0] v,
                                              input logic [W-1:0] lo,
                                              input logic [W-1:0] hi,
                                              input logic [W-1:0] st);
      logic [W:0] floor_v;
      floor_v = {1'b0, lo} + {1'b0, st};
      if ((WRAP != 0) && (v == lo))
         return hi;
      if ({1'b0, v} < floor_v)
         return lo;
      return v - st;
   endfunction

   logic [NB-1:0] btn_raw;
   logic [NB-1:0] vld_p2;

   assign btn_raw = {Dec, Inc};

   for (genvar b = 0; b < NB; b++) begin : g_btn
      logic            sync_p0;
      logic            sync_p1;
      logic            pressed;     // debounced state, 1 = pressed
      logic [DB_W-1:0] db_cnt;
      logic            rpt_first;   // still waiting for the first repeat
      logic [HC_W-1:0] hold_cnt;    // clocks since the last event of this hold
      logic            evt_q;
      logic            differ;
      logic            flip;
      logic            hold_due;

      assign differ   = (~sync_p1) != pressed;
      assign flip     = differ && (db_cnt == DB_LAST);
      assign hold_due = hold_cnt == (rpt_first ? HOLD_FIRST : HOLD_RATE);

      always_ff @(posedge CLK) begin
         if (!Rstn) begin
            // The synchronisers restart as "released". This lets a button
            // that is held through reset show up later as a fresh press.
            sync_p0   <= 1'b1;
            sync_p1   <= 1'b1;
            pressed   <= 1'b0;
            db_cnt    <= '0;
            rpt_first <= 1'b0;
            hold_cnt  <= '0;
            evt_q     <= 1'b0;
         end else begin
            // ---- stage p0/p1: two-flop synchroniser ----
            sync_p0 <= btn_raw[b];
            sync_p1 <= sync_p0;

            // ---- stage p2: debounce and event generation ----
            // Any sample that agrees with the debounced state restarts
            // the stability count.
            if (!differ || flip)
               db_cnt <= '0;
            else
               db_cnt <= db_cnt + DB_W'(1);

            evt_q <= 1'b0;
            if (flip) begin
               pressed <= ~pressed;
               if (!pressed) begin
                  // Press: one immediate event, then arm the hold timer.
                  evt_q     <= 1'b1;
                  rpt_first <= 1'b1;
                  hold_cnt  <= HC_W'(1);
               end else begin
                  // Release: stop the repeat at once.
                  rpt_first <= 1'b0;
                  hold_cnt  <= '0;
               end
            end else if (pressed && (RPT_DELAY != 0)) begin
               if (hold_due) begin
                  evt_q     <= 1'b1;
                  rpt_first <= 1'b0;
                  hold_cnt  <= HC_W'(1);
               end else begin
                  hold_cnt  <= hold_cnt + HC_W'(1);
               end
            end
         end
      end

      assign vld_p2[b] = evt_q;
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      localparam logic [W-1:0] C_INIT = INIT_VEC[c*W +: W];
      localparam logic [W-1:0] C_MIN  = MIN_VEC[c*W +: W];
      localparam logic [W-1:0] C_MAX  = MAX_VEC[c*W +: W];
      localparam logic [W-1:0] C_STEP = STEP_VEC[c*W +: W];

      logic         inc_vld;
      logic         dec_vld;
      logic [W-1:0] next_v;
      logic [W-1:0] value_p3;
      logic         chg_p3;

      assign inc_vld = vld_p2[c];
      assign dec_vld = vld_p2[N_CH + c];

      // Inc and Dec events that arrive in the same clock cancel each other.
      always_comb begin
         next_v = value_p3;
         if (inc_vld && !dec_vld)
            next_v = step_up(value_p3, C_MIN, C_MAX, C_STEP);
         else if (dec_vld && !inc_vld)
            next_v = step_down(value_p3, C_MIN, C_MAX, C_STEP);
      end

      // ---- stage p3: setting register and change pulse ----
      always_ff @(posedge CLK) begin
         if (!Rstn) begin
            value_p3 <= C_INIT;
            chg_p3   <= 1'b0;
         end else begin
            value_p3 <= next_v;
            chg_p3   <= next_v != value_p3;
         end
      end

      assign Value[c*W +: W] = value_p3;
      assign Changed[c]      = chg_p3;
      assign AtMin[c]        = value_p3 == C_MIN;
      assign AtMax[c]        = value_p3 == C_MAX;
   end

endmodule
